// File: rtl/his_builder_reg.sv
// Register-based dTOF histogram builder: counts valid bin addresses during
// acquisition, then streams bins 1..Nb out serially with a type/status code.
module his_builder_reg #(
    parameter int unsigned Np      = 8,
    parameter int unsigned Nb      = 16,
    parameter int unsigned peakMax = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic [1:0]         wrEnable,
    input  logic               acqFinish,
    input  logic [Np:1]        addr,
    output logic [peakMax-1:0] binCounts,
    output logic [1:0]         dataFinish
);

    typedef enum logic [1:0] {StAcq, StRead, StDone} state_e;

    localparam logic [Np-1:0]      LastPtr = Np'(Nb);
    localparam logic [Np-1:0]      OnePtr  = Np'(1);
    localparam logic [peakMax-1:0] CntMax  = '1;

    state_e             state_q, state_d;
    logic [Np-1:0]      ptr_q, ptr_d;
    logic               tag_q, tag_d;
    logic [peakMax-1:0] bin_counts_q, bin_counts_d;
    logic [1:0]         data_finish_q, data_finish_d;
    logic [peakMax-1:0] bins_q [Nb];
    logic [peakMax-1:0] bins_d [Nb];

    logic               addr_valid;
    logic               wr_hit;
    logic [peakMax-1:0] rd_val;

    // The acqFinish cycle's event is deliberately dropped.
    assign addr_valid = (addr != '0) && (addr <= LastPtr);
    assign wr_hit     = (state_q == StAcq) && !acqFinish && wrEnable[0] && addr_valid;

    // Each bin sees its own increment from the registered value, so
    // back-to-back hits on one address never lose a count.
    always_comb begin
        for (int i = 0; i < Nb; i++) begin
            bins_d[i] = bins_q[i];
            if (wr_hit && (addr == Np'(i + 1)) && (bins_q[i] != CntMax)) begin
                bins_d[i] = bins_q[i] + peakMax'(1);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < Nb; i++) begin
            if (ptr_q == Np'(i + 1)) begin
                rd_val = bins_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tag_d         = tag_q;
        bin_counts_d  = '0;
        data_finish_d = 2'b00;
        case (state_q)
            StAcq: begin
                if (acqFinish) begin
                    tag_d   = wrEnable[1];
                    ptr_d   = OnePtr;
                    state_d = StRead;
                end
            end
            StRead: begin
                bin_counts_d  = rd_val;
                data_finish_d = tag_q ? 2'b01 : 2'b10;
                ptr_d         = ptr_q + OnePtr;
                if (ptr_q == LastPtr) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                data_finish_d = 2'b11;
            end
            default: begin
                state_d = StAcq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= StAcq;
            ptr_q         <= OnePtr;
            tag_q         <= 1'b0;
            bin_counts_q  <= '0;
            data_finish_q <= 2'b00;
            for (int i = 0; i < Nb; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tag_q         <= tag_d;
            bin_counts_q  <= bin_counts_d;
            data_finish_q <= data_finish_d;
            for (int i = 0; i < Nb; i++) begin
                bins_q[i] <= bins_d[i];
            end
        end
    end

    assign binCounts  = bin_counts_q;
    assign dataFinish = data_finish_q;

endmodule

// File: tb/tb_his_builder_reg.sv
// Scoreboard bench for his_builder_reg: stimulus queues expected readout words,
// a negedge monitor pops and compares whenever the DUT shows a non-idle status.
module tb_his_builder_reg;

    localparam int Np = 8;
    localparam int Nb = 16;
    localparam int Pk = 8;

    typedef struct packed {
        logic [Pk-1:0] cnt;
        logic [1:0]    code;
    } exp_t;

    logic          clk;
    logic          res;
    logic [1:0]    wrEnable;
    logic          acqFinish;
    logic [Np:1]   addr;
    logic [Pk-1:0] binCounts;
    logic [1:0]    dataFinish;

    exp_t          q[$];
    logic [Pk-1:0] exp_bins [1:Nb];
    bit            in_done;
    int            checks;
    int            errors;

    his_builder_reg #(.Np(Np), .Nb(Nb), .peakMax(Pk)) dut (
        .clk        (clk),
        .res        (res),
        .wrEnable   (wrEnable),
        .acqFinish  (acqFinish),
        .addr       (addr),
        .binCounts  (binCounts),
        .dataFinish (dataFinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                if (dataFinish != 2'b00) begin
                    e = q.pop_front();
                    checks++;
                    if (binCounts !== e.cnt || dataFinish !== e.code) begin
                        errors++;
                        $display("FAIL readout: got binCounts=%0d dataFinish=%b, want %0d/%b",
                                 binCounts, dataFinish, e.cnt, e.code);
                    end
                    if (e.code == 2'b11) in_done = 1'b1;
                end
            end else if ((dataFinish != 2'b00 || binCounts != '0) &&
                         !(in_done && dataFinish == 2'b11 && binCounts == '0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got binCounts=%0d dataFinish=%b, want 0/00",
                         binCounts, dataFinish);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (binCounts !== '0 || dataFinish !== 2'b00) begin
            errors++;
            $display("FAIL %s: got binCounts=%0d dataFinish=%b, want 0/00",
                     name, binCounts, dataFinish);
        end
    endtask

    task automatic do_reset();
        res = 1'b1;
        acqFinish = 1'b0;
        wrEnable = 2'b00;
        addr = '0;
        tick();
        res = 1'b0;
        in_done = 1'b0;
        q.delete();
        check_idle("reset");
        for (int k = 1; k <= Nb; k++) exp_bins[k] = '0;
    endtask

    task automatic wr(input logic [Np-1:0] a, input logic [1:0] we);
        addr = a;
        wrEnable = we;
        tick();
    endtask

    task automatic push_full(input logic [1:0] code);
        for (int k = 1; k <= Nb; k++) q.push_back('{cnt: exp_bins[k], code: code});
        q.push_back('{cnt: '0, code: 2'b11});
    endtask

    // Extra held cycles present a flipped tag and a valid write; both must be ignored.
    task automatic pulse_finish(input logic tag, input logic [Np-1:0] a, input logic we0,
                                input int hold);
        acqFinish = 1'b1;
        wrEnable = {tag, we0};
        addr = a;
        tick();
        for (int h = 1; h < hold; h++) begin
            wrEnable = {~tag, 1'b1};
            addr = 1;
            tick();
        end
        acqFinish = 1'b0;
        wrEnable = 2'b00;
        addr = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: readout incomplete, got %0d words left, want 0", name, q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        logic [Np-1:0] seq [10];
        checks = 0;
        errors = 0;
        in_done = 1'b0;
        res = 1'b0;
        acqFinish = 1'b0;
        wrEnable = 2'b00;
        addr = '0;
        seq = '{1, 1, 2, 2, 3, 1, 2, 3, 3, 3};

        // Basic coarse histogram
        do_reset();
        foreach (seq[i]) wr(seq[i], 2'b11);
        exp_bins[1] = 3;
        exp_bins[2] = 3;
        exp_bins[3] = 4;
        push_full(2'b01);
        pulse_finish(1'b1, '0, 1'b0, 1);
        wait_drain("coarse_basic");

        // Count enable clear: nothing counted
        do_reset();
        foreach (seq[i]) wr(seq[i], 2'b10);
        push_full(2'b01);
        pulse_finish(1'b1, '0, 1'b0, 1);
        wait_drain("no_enable");

        // Fine tag, acqFinish held for three cycles
        do_reset();
        wr(4, 2'b01);
        wr(4, 2'b01);
        wr(16, 2'b01);
        exp_bins[4] = 2;
        exp_bins[16] = 1;
        push_full(2'b10);
        pulse_finish(1'b0, '0, 1'b0, 3);
        wait_drain("fine_hold");

        // Out-of-range addresses and a write in the acqFinish cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(0, 2'b11);
            wr(Nb + 1, 2'b11);
            wr(255, 2'b11);
        end
        push_full(2'b01);
        pulse_finish(1'b1, 1, 1'b1, 1);
        wait_drain("bad_addr");

        // Saturation with back-to-back writes
        do_reset();
        for (int i = 0; i < (1 << Pk) + 5; i++) wr(5, 2'b01);
        exp_bins[5] = 8'd255;
        push_full(2'b10);
        pulse_finish(1'b0, '0, 1'b0, 1);
        wait_drain("saturate");

        // Reset at E0+4 aborts readout and clears bins
        do_reset();
        wr(1, 2'b11);
        wr(2, 2'b11);
        wr(3, 2'b11);
        for (int k = 0; k < 3; k++) q.push_back('{cnt: 8'd1, code: 2'b01});
        pulse_finish(1'b1, '0, 1'b0, 1);
        repeat (3) tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        in_done = 1'b0;
        check_idle("mid_reset");
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_words: got %0d words left, want 0", q.size());
        end
        for (int k = 1; k <= Nb; k++) exp_bins[k] = '0;
        push_full(2'b01);
        pulse_finish(1'b1, '0, 1'b0, 1);
        wait_drain("after_mid_reset");

        // Reset wins over simultaneous acqFinish
        res = 1'b1;
        acqFinish = 1'b1;
        wrEnable = 2'b11;
        addr = 1;
        tick();
        res = 1'b0;
        acqFinish = 1'b0;
        wrEnable = 2'b00;
        addr = '0;
        in_done = 1'b0;
        check_idle("res_and_acq");
        tick();
        check_idle("res_and_acq_next");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
